// File: rtl/spike_pkg.sv
// rtl/spike_pkg.sv - shared types and helpers for the spike interval decoder
package spike_pkg;

  localparam int DEF_CNT_W = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] interval;
    logic                 timeout;
  } result_t;

  // Largest value a w-bit counter can hold; the interval counter saturates here.
  function automatic int unsigned sat_of(input int unsigned w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/spike_sync_edge.sv
// rtl/spike_sync_edge.sv - spike_in synchroniser plus registered rising-edge pulse
module spike_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spike_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d_q;

  // The pulse is registered, so it appears SYNC_STAGES+1 clocks after spike_in rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      sync_d_q   <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], spike_in};
      sync_d_q   <= sync_q[SYNC_STAGES-1];
      edge_pulse <= sync_q[SYNC_STAGES-1] & ~sync_d_q;
    end
  end

endmodule

// File: rtl/spike_interval_decoder.sv
// rtl/spike_interval_decoder.sv - measures cycles between spike edges, valid/ready output
module spike_interval_decoder
  import spike_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             spike_in,
  input  logic             clear_overrun,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [CNT_W-1:0] interval_out,
  output logic             timeout_out,
  output logic             overrun_out
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_of(CNT_W));
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef struct packed {
    logic [CNT_W-1:0] interval;
    logic             timeout;
  } result_w_t;

  logic       edge_pulse;
  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       cap;
  result_w_t  cap_res;
  result_w_t  hold_q;
  logic       valid_q;
  logic       overrun_q;

  spike_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .spike_in  (spike_in),
    .edge_pulse(edge_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    cap_res = '0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (edge_pulse) begin
            state_d = MEASURE;
            cnt_d   = ONE;
          end
        end
        MEASURE: begin
          // An edge beats the timeout, so an edge at cnt == SAT is a normal result.
          if (edge_pulse) begin
            cap              = 1'b1;
            cap_res.interval = cnt_q;
            cnt_d            = ONE;
          end else if (cnt_q == SAT) begin
            cap              = 1'b1;
            cap_res.interval = SAT;
            cap_res.timeout  = 1'b1;
            state_d          = IDLE;
            cnt_d            = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Single holding register: a capture while the held result is stalled is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (cap && valid_q && !ready_in) begin
        overrun_q <= 1'b1;
      end else if (clear_overrun) begin
        overrun_q <= 1'b0;
      end
      if (cap && (!valid_q || ready_in)) begin
        hold_q  <= cap_res;
        valid_q <= 1'b1;
      end else if (valid_q && ready_in) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_out    = valid_q;
  assign interval_out = hold_q.interval;
  assign timeout_out  = hold_q.timeout;
  assign overrun_out  = overrun_q;

endmodule
